// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: client index type, read-return pipeline entry and one-hot/index helpers
package ram_arb_pkg;
    localparam int CLIENTS = 4;
    localparam int IDX_W = $clog2(CLIENTS);
    typedef logic [IDX_W-1:0] idx_t;
    typedef struct packed {
        logic valid;
        idx_t idx;
    } pipe_t;
    function automatic logic [CLIENTS-1:0] idx_to_onehot(input idx_t i);
        idx_to_onehot = '0;
        idx_to_onehot[i] = 1'b1;
    endfunction
    function automatic idx_t onehot_to_idx(input logic [CLIENTS-1:0] oh);
        onehot_to_idx = '0;
        for (int k = 0; k < CLIENTS; k++)
            onehot_to_idx |= oh[k] ? idx_t'(k) : '0;
    endfunction
endpackage

// File: rtl/ram_arb_rr_pick.sv
// ram_arb_rr_pick: combinational round-robin winner search upward from ptr
module ram_arb_rr_pick
    import ram_arb_pkg::*;
#(
    parameter int N = CLIENTS
)(
    input  logic [N-1:0] elig,
    input  idx_t         ptr,
    output logic [N-1:0] win_oh,
    output idx_t         win_idx
);
    idx_t c;
    always_comb begin
        win_idx = '0;
        c = '0;
        // descending scan so the candidate nearest the pointer is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            c = idx_t'((int'(ptr) + i) % N);
            if (elig[c]) win_idx = c;
        end
        win_oh = |elig ? idx_to_onehot(win_idx) : '0;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin single-port RAM sharing with routed read return; bus locking when RAM_ARB_LOCK_EN is defined
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_CLIENTS  = CLIENTS,
    parameter int READ_LATENCY = 1
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS-1:0]            we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_CLIENTS-1:0]            lock,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic [NUM_CLIENTS-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]             rdata,
    input  logic [DATA_WIDTH-1:0]             ram_out,
    output logic [ADDR_WIDTH-1:0]             ram_address,
    output logic [DATA_WIDTH-1:0]             ram_in,
    output logic                              ram_write_enable
);
    idx_t p, win_idx;
    logic [NUM_CLIENTS-1:0] elig, win_oh;
    pipe_t issue;
    pipe_t pipe [READ_LATENCY];

`ifdef RAM_ARB_LOCK_EN
    logic owned;
    idx_t owner;
    always_comb elig = req & ~grant & ((owned && lock[owner]) ? idx_to_onehot(owner) : '1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owned <= 1'b0;
            owner <= '0;
        end else if (|win_oh && lock[win_idx]) begin
            owned <= 1'b1;
            owner <= win_idx;
        end else if (!lock[owner]) begin
            owned <= 1'b0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    always_comb elig = req & ~grant;
`endif

    ram_arb_rr_pick #(.N(NUM_CLIENTS)) u_pick (
        .elig    (elig),
        .ptr     (p),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // the read enters the return pipeline as the RAM samples its address
    always_comb issue = '{valid: |grant & ~ram_write_enable, idx: onehot_to_idx(grant)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant            <= '0;
            rvalid           <= '0;
            rdata            <= '0;
            ram_address      <= '0;
            ram_in           <= '0;
            ram_write_enable <= 1'b0;
            p                <= '0;
            pipe             <= '{default: '0};
        end else begin
            grant            <= win_oh;
            ram_write_enable <= |win_oh & we[win_idx];
            if (|win_oh) begin
                ram_address <= addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                ram_in      <= wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                p           <= (win_idx == idx_t'(NUM_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
            end
            pipe[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++)
                pipe[i] <= pipe[i-1];
            rvalid <= pipe[READ_LATENCY-1].valid ? idx_to_onehot(pipe[READ_LATENCY-1].idx) : '0;
            if (pipe[READ_LATENCY-1].valid)
                rdata <= ram_out;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural one-cycle RAM
module tb_ram_arbiter;
    logic        clk, reset;
    logic [3:0]  req, we, lock, grant, rvalid;
    logic [31:0] addr, wdata;
    logic [7:0]  rdata, ram_out, ram_address, ram_in;
    logic        ram_write_enable;
    logic [7:0]  mem [256];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n;

    typedef struct { int c; logic [3:0] oh; logic [7:0] a; logic [7:0] d; logic w; } gexp_t;
    typedef struct { int c; logic [3:0] oh; logic [7:0] d; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t g;
    rexp_t r;

    ram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .lock             (lock),
        .grant            (grant),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .ram_out          (ram_out),
        .ram_address      (ram_address),
        .ram_in           (ram_in),
        .ram_write_enable (ram_write_enable)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_address] <= ram_in;
        ram_out <= mem[ram_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_g(input int c, input int cl, input logic [7:0] a, input logic [7:0] d, input logic w);
        gq.push_back('{c, 4'(1 << cl), a, d, w});
    endtask

    task automatic exp_r(input int c, input int cl, input logic [7:0] d);
        rq.push_back('{c, 4'(1 << cl), d});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (grant != 0) begin
                tests++;
                if (gq.size() == 0) begin
                    fails++;
                    $display("FAIL grant: got %b at cycle %0d, required none", grant, cyc);
                end else begin
                    g = gq.pop_front();
                    if (grant !== g.oh || cyc != g.c || ram_address !== g.a || ram_in !== g.d || ram_write_enable !== g.w) begin
                        fails++;
                        $display("FAIL grant: got oh=%b cyc=%0d addr=%h din=%h we=%b, required oh=%b cyc=%0d addr=%h din=%h we=%b",
                                 grant, cyc, ram_address, ram_in, ram_write_enable, g.oh, g.c, g.a, g.d, g.w);
                    end
                end
            end else if (ram_write_enable) begin
                tests++;
                fails++;
                $display("FAIL ram_we: got 1 without grant at cycle %0d, required 0", cyc);
            end
            if (rvalid != 0) begin
                tests++;
                if (rq.size() == 0) begin
                    fails++;
                    $display("FAIL rvalid: got %b at cycle %0d, required none", rvalid, cyc);
                end else begin
                    r = rq.pop_front();
                    if (rvalid !== r.oh || cyc != r.c || rdata !== r.d) begin
                        fails++;
                        $display("FAIL rvalid: got oh=%b cyc=%0d rdata=%h, required oh=%b cyc=%0d rdata=%h",
                                 rvalid, cyc, rdata, r.oh, r.c, r.d);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1; req = 0; we = 0; addr = 0; wdata = 0; lock = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[5] = 8'h3C;
        repeat (3) begin
            tick();
            req = 4'($urandom); we = 4'($urandom); lock = 4'($urandom);
            addr = $urandom; wdata = $urandom;
        end
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_addr", 32'(ram_address), 0);
        chk("rst_din", 32'(ram_in), 0);
        chk("rst_we", 32'(ram_write_enable), 0);

        // release: lowest-index requester first
        tick(); n = cyc;
        reset = 0; lock = 0; req = 4'b1100; we = 4'b1100;
        addr = {8'h33, 8'h22, 8'h11, 8'h00}; wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        exp_g(n + 1, 2, 8'h22, 8'hC2, 1);
        tick(); req = 4'b1000;
        exp_g(n + 2, 3, 8'h33, 8'hD3, 1);
        tick(); req = 0;
        tick();

        // all four continuously, then client 0 alone
        n = cyc; req = 4'b1111; we = 4'b1111;
        addr = {8'h43, 8'h42, 8'h41, 8'h40}; wdata = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        exp_g(n + 1, 0, 8'h40, 8'hF0, 1);
        exp_g(n + 2, 1, 8'h41, 8'hF1, 1);
        exp_g(n + 3, 2, 8'h42, 8'hF2, 1);
        exp_g(n + 4, 3, 8'h43, 8'hF3, 1);
        exp_g(n + 5, 0, 8'h40, 8'hF0, 1);
        exp_g(n + 6, 1, 8'h41, 8'hF1, 1);
        repeat (6) tick();
        req = 0;
        tick();
        n = cyc; req = 4'b0001;
        exp_g(n + 1, 0, 8'h40, 8'hF0, 1);
        exp_g(n + 3, 0, 8'h40, 8'hF0, 1);
        exp_g(n + 5, 0, 8'h40, 8'hF0, 1);
        repeat (5) tick();
        req = 0;
        tick();

        // client 2 writes 0xAB to 0x10
        n = cyc; req = 4'b0100; we = 4'b0100;
        addr = {8'h00, 8'h10, 8'h00, 8'h00}; wdata = {8'h00, 8'hAB, 8'h00, 8'h00};
        exp_g(n + 1, 2, 8'h10, 8'hAB, 1);
        tick(); req = 0;
        repeat (2) tick();

        // client 1 reads 0x05 holding 0x3C
        n = cyc; req = 4'b0010; we = 0;
        addr = {8'h00, 8'h00, 8'h05, 8'h00}; wdata = 0;
        exp_g(n + 1, 1, 8'h05, 8'h00, 0);
        exp_r(n + 3, 1, 8'h3C);
        tick(); req = 0;
        repeat (3) tick();

        // lock sequence: client 1 locks while 0 and 2 request
        n = cyc; req = 4'b0010; lock = 4'b0010; we = 4'b1111;
        addr = {8'h63, 8'h62, 8'h61, 8'h60}; wdata = {8'h93, 8'h92, 8'h91, 8'h90};
`ifdef RAM_ARB_LOCK_EN
        exp_g(n + 1, 1, 8'h61, 8'h91, 1);
        exp_g(n + 3, 1, 8'h61, 8'h91, 1);
        exp_g(n + 5, 1, 8'h61, 8'h91, 1);
        exp_g(n + 6, 2, 8'h62, 8'h92, 1);
        exp_g(n + 7, 0, 8'h60, 8'h90, 1);
`else
        exp_g(n + 1, 1, 8'h61, 8'h91, 1);
        exp_g(n + 2, 2, 8'h62, 8'h92, 1);
        exp_g(n + 3, 0, 8'h60, 8'h90, 1);
        exp_g(n + 4, 1, 8'h61, 8'h91, 1);
        exp_g(n + 5, 2, 8'h62, 8'h92, 1);
        exp_g(n + 6, 0, 8'h60, 8'h90, 1);
        exp_g(n + 7, 1, 8'h61, 8'h91, 1);
`endif
        tick(); req = 4'b0111;
        repeat (4) tick();
        lock = 0;
        tick(); req = 4'b0011;
        tick(); req = 0;
        repeat (2) tick();

        // reset one cycle after a read grant discards the read
        n = cyc; req = 4'b1000; we = 0;
        addr = {8'h07, 8'h00, 8'h00, 8'h00}; wdata = 0;
        exp_g(n + 1, 3, 8'h07, 8'h00, 0);
        tick(); req = 0;
        tick(); reset = 1;
        tick(); reset = 0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", {29'd0, |rvalid, |grant, ram_write_enable}, 0);
        end

        // read back the earlier write
        tick(); n = cyc; req = 4'b0001; we = 0;
        addr = {8'h00, 8'h00, 8'h00, 8'h10}; wdata = 0;
        exp_g(n + 1, 0, 8'h10, 8'h00, 0);
        exp_r(n + 3, 0, 8'hAB);
        tick(); req = 0;
        repeat (4) tick();

        chk("pending_expect", 32'(gq.size() + rq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
